// File: rtl/fir_sample_src.sv
// Sample source feeding the FIR filter: a local block of signed samples is
// streamed out as one-cycle din/en strobes at a programmable period after start.
module fir_sample_src #(
  parameter int N2    = 16,
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [N2-1:0]    wr_data,
  input  logic             start,
  input  logic             abort,
  input  logic [AW:0]      num_samples,
  input  logic [DIV_W-1:0] period,
  output logic             en,
  output logic [N2-1:0]    din,
  output logic [31:0]      sample_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EMIT, S_WAIT, S_DONE} state_t;

  localparam logic [AW:0]      MAX_CNT = (AW+1)'(DEPTH);
  localparam logic [DIV_W-1:0] MIN_PER = DIV_W'(2);

  state_t           state_q, state_d;
  logic [N2-1:0]    mem [DEPTH];
  logic [N2-1:0]    din_q;
  logic [AW:0]      cnt_q, rd_ptr_q, idx_q;
  logic [DIV_W-1:0] per_q, timer_q;
  logic [AW:0]      cnt_in;
  logic [DIV_W-1:0] per_in;
  logic             launch, last;

  // Run length saturates at the RAM depth; the period floor is the FETCH+EMIT pair.
  assign cnt_in = (num_samples > MAX_CNT) ? MAX_CNT : num_samples;
  assign per_in = (period < MIN_PER) ? MIN_PER : period;
  assign launch = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !abort;
  assign last   = (rd_ptr_q + (AW+1)'(1)) == cnt_q;

  // NOTE: the sample array carries no reset; only the read register does, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (launch) state_d = (cnt_in == '0) ? S_DONE : S_FETCH;
        S_FETCH:        state_d = S_EMIT;
        S_EMIT: begin
          if (last)                 state_d = S_DONE;
          else if (per_q == MIN_PER) state_d = S_FETCH;
          else                      state_d = S_WAIT;
        end
        S_WAIT:         if (timer_q == '0) state_d = S_FETCH;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // The read register doubles as din: it only loads in FETCH, so din holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      per_q    <= MIN_PER;
      timer_q  <= '0;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      din_q    <= '0;
    end else if (!abort) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt_q    <= cnt_in;
            per_q    <= per_in;
            rd_ptr_q <= '0;
          end
        end
        S_FETCH: begin
          din_q <= mem[rd_ptr_q[AW-1:0]];
          idx_q <= rd_ptr_q;
        end
        S_EMIT: begin
          rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
          timer_q  <= per_q - DIV_W'(3);
        end
        S_WAIT: begin
          if (timer_q != '0) timer_q <= timer_q - DIV_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    en   = (state_q == S_EMIT) && !abort;
    busy = (state_q == S_FETCH) || (state_q == S_EMIT) || (state_q == S_WAIT);
    done = (state_q == S_DONE);
  end

  assign din        = din_q;
  assign sample_idx = 32'(idx_q);

endmodule

// File: tb/tb_fir_sample_src.sv
// Directed bench for fir_sample_src: a table of runs checked against a RAM
// shadow, plus hand-written abort, restart, collision and reset sequences.
module tb_fir_sample_src;

  localparam int N2    = 16;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [N2-1:0]    wr_data = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [AW:0]      num_samples = '0;
  logic [DIV_W-1:0] period = '0;
  logic             en;
  logic [N2-1:0]    din;
  logic [31:0]      sample_idx;
  logic             busy;
  logic             done;

  fir_sample_src #(.N2(N2), .DEPTH(DEPTH), .AW(AW), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort),
    .num_samples(num_samples), .period(period),
    .en(en), .din(din), .sample_idx(sample_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW:0]      num;
    logic [DIV_W-1:0] per;
    int               pulses;
    int               gap;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [N2-1:0] model_mem [DEPTH];
  vec_t          vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [N2-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the edge that samples start.
  task automatic run_vec(input string tag, input logic [AW:0] num, input logic [DIV_W-1:0] per,
                         input int exp_pulses, input int exp_gap);
    int n = 0;
    int last_c = 0;
    int done_c = 0;
    int busy_bad = 0;
    num_samples = num;
    period      = per;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    num_samples = 8'd5;
    period      = 16'd9;
    check($sformatf("%s busy_c1", tag), 32'(busy), 32'(exp_pulses != 0));
    check($sformatf("%s done_c1", tag), 32'(done), 32'(exp_pulses == 0));
    for (int c = 1; c <= 2000; c++) begin
      if (en) begin
        check($sformatf("%s en_cycle[%0d]", tag, n), 32'(c), 32'(2 + n * exp_gap));
        check($sformatf("%s din[%0d]", tag, n), 32'(din), (n < DEPTH) ? 32'(model_mem[n]) : 32'hdead);
        check($sformatf("%s idx[%0d]", tag, n), sample_idx, 32'(n));
        n++;
        last_c = c;
      end
      if (done) begin
        done_c = c;
        break;
      end
      if (!busy) busy_bad++;
      tick();
    end
    check($sformatf("%s pulses", tag), 32'(n), 32'(exp_pulses));
    check($sformatf("%s done_cycle", tag), 32'(done_c), 32'(last_c + 1));
    check($sformatf("%s busy_gaps", tag), 32'(busy_bad), 32'd0);
    if (exp_pulses > 0) begin
      tick();
      tick();
      check($sformatf("%s done_hold", tag), 32'(done), 32'd1);
      check($sformatf("%s din_hold", tag), 32'(din), 32'(model_mem[exp_pulses - 1]));
      check($sformatf("%s idx_hold", tag), sample_idx, 32'(exp_pulses - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int guard;
    logic [N2-1:0] old0;

    vecs[0] = '{8'd8,   16'd4, 8,   4};
    vecs[1] = '{8'd4,   16'd0, 4,   2};
    vecs[2] = '{8'd4,   16'd1, 4,   2};
    vecs[3] = '{8'd4,   16'd2, 4,   2};
    vecs[4] = '{8'd0,   16'd4, 0,   0};
    vecs[5] = '{8'd200, 16'd2, 128, 2};
    vecs[6] = '{8'd10,  16'd2, 10,  2};
    vecs[7] = '{8'd3,   16'd7, 3,   7};
    vecs[8] = '{8'd128, 16'd3, 128, 3};

    tick();
    check("reset en", 32'(en), 32'd0);
    check("reset din", 32'(din), 32'd0);
    check("reset idx", sample_idx, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      if (i < 8)       model_mem[i] = N2'(100 + i);
      else if (i == 8) model_mem[i] = 16'h8000;
      else if (i == 9) model_mem[i] = 16'h7fff;
      else             model_mem[i] = N2'(i * 37 - 1000);
      wr(i, model_mem[i]);
    end

    for (int v = 0; v < 9; v++)
      run_vec($sformatf("vec%0d", v), vecs[v].num, vecs[v].per, vecs[v].pulses, vecs[v].gap);

    // Abort in the cycle after the third strobe, then restart from sample 0.
    num_samples = 8'd8; period = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; guard = 0;
    while (n < 3 && guard < 40) begin
      if (en) n++;
      if (n < 3) begin tick(); guard++; end
    end
    check("abort third_en_seen", 32'(n), 32'd3);
    tick();
    abort = 1'b1;
    #1;
    check("abort en_low", 32'(en), 32'd0);
    tick();
    abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort din_hold", 32'(din), 32'(model_mem[2]));
    check("abort idx_hold", sample_idx, 32'd2);
    n = 0;
    repeat (20) begin tick(); if (en || busy) n++; end
    check("abort quiet", 32'(n), 32'd0);
    run_vec("restart", 8'd2, 16'd2, 2, 2);

    // Abort arriving in the strobe cycle itself suppresses en at once.
    num_samples = 8'd4; period = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    #1;
    check("abort_emit en", 32'(en), 32'd0);
    tick();
    abort = 1'b0;
    check("abort_emit busy", 32'(busy), 32'd0);

    // A start pulse mid-run changes nothing.
    num_samples = 8'd4; period = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int c = 1; c <= 60 && !done; c++) begin
      if (en) n++;
      if (c == 4) begin start = 1'b1; num_samples = 8'd8; end
      else start = 1'b0;
      tick();
    end
    start = 1'b0;
    check("midrun_start pulses", 32'(n), 32'd4);
    check("midrun_start done", 32'(done), 32'd1);

    // start together with abort: abort wins, block sits in IDLE.
    num_samples = 8'd4; period = 16'd2; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort busy", 32'(busy), 32'd0);
    check("start_abort done", 32'(done), 32'd0);
    n = 0;
    repeat (8) begin tick(); if (en) n++; end
    check("start_abort no_en", 32'(n), 32'd0);

    // A write landing on the address being fetched returns the old word.
    old0 = model_mem[0];
    num_samples = 8'd1; period = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wr(0, 16'h1234);
    check("collide en", 32'(en), 32'd1);
    check("collide old_data", 32'(din), 32'(old0));
    model_mem[0] = 16'h1234;
    tick();
    check("collide done", 32'(done), 32'd1);
    run_vec("new_data", 8'd1, 16'd2, 1, 2);

    // Asynchronous reset mid-run; RAM contents survive.
    num_samples = 8'd8; period = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst en", 32'(en), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst din", 32'(din), 32'd0);
    check("midrst idx", sample_idx, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_vec("after_reset", 8'd10, 16'd2, 10, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
